// File: rtl/mdu_sequencer.sv
// ---------------------------------------------------------------------------
// mdu_sequencer
//
// Purpose:
//   Multi-cycle multiply/divide unit with architectural HI/LO registers for
//   the P7 pipeline. It sits in EX beside the ALU. A mult/multu/div/divu
//   computes its result when it is accepted and parks it in pending
//   registers. The pending value is copied into HI/LO only after the modelled
//   latency has run out, so software sees a realistic busy window. mthi/mtlo
//   write HI/LO directly at the next edge and never raise busy.
//
// Parameters:
//   MULT_CYCLES  busy cycles for mult/multu (>=1)
//   DIV_CYCLES   busy cycles for div/divu   (>=1)
//
// Ports:
//   clk    in   1   clock, all state updates on the rising edge
//   reset  in   1   synchronous active-high reset
//   start  in   1   EX holds a valid multiply/divide-unit op this cycle
//   op     in   3   1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, else no-op
//   flush  in   1   EX instruction squashed; blocks acceptance
//   A      in   32  GPR[rs] (forwarded)
//   B      in   32  GPR[rt] (forwarded)
//   busy   out  1   multi-cycle op in progress
//   HI     out  32  HI register
//   LO     out  32  LO register
// ---------------------------------------------------------------------------
module mdu_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic        flush,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               busy_q, busy_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic [31:0]        pend_hi_q, pend_hi_d;
    logic [31:0]        pend_lo_q, pend_lo_d;

    logic               accept;
    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        div_s_q, div_s_r;
    logic [31:0]        div_u_q, div_u_r;

    // Results are computed combinationally from the operands present at
    // acceptance; the counter only models how long the real unit would take.
    // Sign-extending to 64 bits makes the low 64 bits of the product the
    // exact signed result.
    always_comb begin
        prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u = {32'd0, A} * {32'd0, B};
    end

    // Divide-by-zero and the single signed overflow case (most negative
    // number divided by -1) get fixed architectural results instead of
    // relying on whatever the operator does with them.
    always_comb begin
        div_s_q = 32'hFFFF_FFFF;
        div_s_r = A;
        div_u_q = 32'hFFFF_FFFF;
        div_u_r = A;
        if (B != 32'd0) begin
            div_u_q = A / B;
            div_u_r = A % B;
            if ((A == 32'h8000_0000) && (B == 32'hFFFF_FFFF)) begin
                div_s_q = 32'h8000_0000;
                div_s_r = 32'd0;
            end else begin
                div_s_q = $signed(A) / $signed(B);
                div_s_r = $signed(A) % $signed(B);
            end
        end
    end

    // Requests are taken only while idle and not squashed; a start that
    // arrives during RUN is dropped without touching the running op.
    assign accept = start & ~flush & (state_q == IDLE);

    // Next-state logic. The counter is loaded with N on acceptance and the
    // commit happens on the edge where it reads 1, giving exactly N busy
    // cycles with the new HI/LO appearing in the same cycle busy drops.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        busy_d    = busy_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (op)
                        3'd1: begin
                            pend_hi_d = prod_s[63:32];
                            pend_lo_d = prod_s[31:0];
                            count_d   = CNT_W'(MULT_CYCLES);
                            busy_d    = 1'b1;
                            state_d   = RUN;
                        end
                        3'd2: begin
                            pend_hi_d = prod_u[63:32];
                            pend_lo_d = prod_u[31:0];
                            count_d   = CNT_W'(MULT_CYCLES);
                            busy_d    = 1'b1;
                            state_d   = RUN;
                        end
                        3'd3: begin
                            pend_hi_d = div_s_r;
                            pend_lo_d = div_s_q;
                            count_d   = CNT_W'(DIV_CYCLES);
                            busy_d    = 1'b1;
                            state_d   = RUN;
                        end
                        3'd4: begin
                            pend_hi_d = div_u_r;
                            pend_lo_d = div_u_q;
                            count_d   = CNT_W'(DIV_CYCLES);
                            busy_d    = 1'b1;
                            state_d   = RUN;
                        end
                        3'd5: hi_d = A;
                        3'd6: lo_d = A;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (count_q <= CNT_W'(1)) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    busy_d  = 1'b0;
                    count_d = '0;
                    state_d = IDLE;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            default: begin
                busy_d  = 1'b0;
                count_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Single state register; reset aborts any op in flight, so pending
    // results are discarded along with HI/LO.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            busy_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

    assign busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mdu_sequencer
//
// Directed bench for mdu_sequencer with hand-computed expected values.
// Inputs change 1 time unit after the rising edge and outputs are sampled at
// the same point, so nothing races the clock edge.
// ---------------------------------------------------------------------------
module tb_mdu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic        flush;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int assert_count = 0;
    int fail_count   = 0;

    mdu_sequencer #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .flush (flush),
        .A     (a_in),
        .B     (b_in),
        .busy  (busy),
        .HI    (hi),
        .LO    (lo)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Every comparison goes through here so the totals stay consistent.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Hold one request for exactly one rising edge, then drop it.
    task automatic applyStimulus(input logic [2:0] op_v, input logic [31:0] a_v,
                                 input logic [31:0] b_v, input logic flush_v);
        start = 1'b1;
        op    = op_v;
        a_in  = a_v;
        b_in  = b_v;
        flush = flush_v;
        stepCycle();
        start = 1'b0;
        flush = 1'b0;
        op    = 3'd0;
    endtask

    // Count busy cycles from now until busy drops, bounded so a stuck DUT
    // shows up as a wrong cycle count rather than a hang.
    task automatic waitIdle(output int n);
        n = 0;
        while ((busy === 1'b1) && (n < 100)) begin
            n++;
            stepCycle();
        end
    endtask

    // Issue a multi-cycle op and check busy length, HI/LO hold and result.
    task automatic runOp(input string tag, input logic [2:0] op_v,
                         input logic [31:0] a_v, input logic [31:0] b_v,
                         input int exp_cycles,
                         input logic [31:0] prev_hi, input logic [31:0] prev_lo,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        applyStimulus(op_v, a_v, b_v, 1'b0);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd1);
        checkOutput({tag, "_hold_hi"}, 64'(hi), 64'(prev_hi));
        checkOutput({tag, "_hold_lo"}, 64'(lo), 64'(prev_lo));
        waitIdle(n);
        checkOutput({tag, "_cycles"}, 64'(n), 64'(exp_cycles));
        checkOutput({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        checkOutput({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    endtask

    // Safety net in case something stalls the main sequence entirely.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main directed sequence.
    initial begin
        int n;
        reset = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        flush = 1'b0;
        a_in  = 32'd0;
        b_in  = 32'd0;
        repeat (3) stepCycle();
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_hi", 64'(hi), 64'd0);
        checkOutput("reset_lo", 64'(lo), 64'd0);
        reset = 1'b0;
        stepCycle();

        // mult -3 * 7 = -21
        runOp("mult", 3'd1, 32'hFFFF_FFFD, 32'd7, 5,
              32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        // multu 0xFFFFFFFF * 2 = 0x1_FFFFFFFE
        runOp("multu", 3'd2, 32'hFFFF_FFFF, 32'd2, 5,
              32'hFFFF_FFFF, 32'hFFFF_FFEB, 32'd1, 32'hFFFF_FFFE);
        // div -7 / 2 = -3 remainder -1
        runOp("div", 3'd3, 32'hFFFF_FFF9, 32'd2, 10,
              32'd1, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        // divu 7 / 0
        runOp("divu0", 3'd4, 32'd7, 32'd0, 10,
              32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF);

        // Flushed mult must not start.
        applyStimulus(3'd1, 32'd5, 32'd5, 1'b1);
        checkOutput("flush_busy", 64'(busy), 64'd0);
        checkOutput("flush_hi", 64'(hi), 64'd7);
        checkOutput("flush_lo", 64'(lo), 64'hFFFF_FFFF);
        stepCycle();
        checkOutput("flush_busy_later", 64'(busy), 64'd0);

        // Flushed mthi must not write HI.
        applyStimulus(3'd5, 32'h0000_AAAA, 32'd0, 1'b1);
        checkOutput("flush_mthi_hi", 64'(hi), 64'd7);

        // op 7 is a no-op.
        applyStimulus(3'd7, 32'd99, 32'd99, 1'b0);
        checkOutput("op7_busy", 64'(busy), 64'd0);
        checkOutput("op7_hi", 64'(hi), 64'd7);
        checkOutput("op7_lo", 64'(lo), 64'hFFFF_FFFF);

        // mthi then mtlo on consecutive cycles.
        applyStimulus(3'd5, 32'd1234, 32'd0, 1'b0);
        checkOutput("mthi_hi", 64'(hi), 64'd1234);
        checkOutput("mthi_lo", 64'(lo), 64'hFFFF_FFFF);
        checkOutput("mthi_busy", 64'(busy), 64'd0);
        applyStimulus(3'd6, 32'd5678, 32'd0, 1'b0);
        checkOutput("mtlo_hi", 64'(hi), 64'd1234);
        checkOutput("mtlo_lo", 64'(lo), 64'd5678);
        checkOutput("mtlo_busy", 64'(busy), 64'd0);

        // A second mult during RUN is ignored: original 2*3 completes on time.
        applyStimulus(3'd1, 32'd2, 32'd3, 1'b0);
        checkOutput("ign_busy1", 64'(busy), 64'd1);
        applyStimulus(3'd1, 32'd100, 32'd100, 1'b0);
        checkOutput("ign_busy2", 64'(busy), 64'd1);
        checkOutput("ign_hold_hi", 64'(hi), 64'd1234);
        checkOutput("ign_hold_lo", 64'(lo), 64'd5678);
        waitIdle(n);
        checkOutput("ign_cycles_left", 64'(n), 64'd4);
        checkOutput("ign_hi", 64'(hi), 64'd0);
        checkOutput("ign_lo", 64'(lo), 64'd6);

        // Back-to-back: issued in the first cycle busy is low. (-1)*(-1) = 1
        runOp("b2b", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,
              32'd0, 32'd6, 32'd0, 32'd1);

        // Reset in the 3rd busy cycle of a div aborts it without commit.
        applyStimulus(3'd3, 32'd100, 32'd7, 1'b0);
        stepCycle();
        stepCycle();
        checkOutput("rst_mid_busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        stepCycle();
        reset = 1'b0;
        checkOutput("rst_mid_busy", 64'(busy), 64'd0);
        checkOutput("rst_mid_hi", 64'(hi), 64'd0);
        checkOutput("rst_mid_lo", 64'(lo), 64'd0);
        repeat (12) stepCycle();
        checkOutput("rst_late_busy", 64'(busy), 64'd0);
        checkOutput("rst_late_hi", 64'(hi), 64'd0);
        checkOutput("rst_late_lo", 64'(lo), 64'd0);

        // Signed overflow divide; HI preloaded so its clear is visible.
        applyStimulus(3'd5, 32'd55, 32'd0, 1'b0);
        checkOutput("pre_ovf_hi", 64'(hi), 64'd55);
        runOp("divovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10,
              32'd55, 32'd0, 32'd0, 32'h8000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assert_count, fail_count);
        $finish;
    end

endmodule
